// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel debouncer for push-buttons and switches.
// Each channel runs through a 2-FF synchroniser and is sampled on a shared
// prescaler tick. A new level is accepted only after STABLE consecutive
// differing samples. Accepted edges produce rise/fall strobes. Channels
// enabled in RPT_MASK also produce auto-repeat press strobes while held high.
module debounce_bank #(
  parameter int               N_CH     = 9,
  parameter int               DIV      = 201,
  parameter int               STABLE   = 6,
  parameter int               RPT_DLY  = 50,
  parameter int               RPT_RATE = 20,
  parameter logic [N_CH-1:0]  RPT_MASK = 9'b000000011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press,
  output logic            tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam int HW = $clog2(RPT_DLY + 1);

  localparam logic [PW-1:0] PCNT_LAST   = PW'(DIV - 1);
  localparam logic [SW-1:0] SCNT_LAST   = SW'(STABLE - 1);
  localparam logic [HW-1:0] HCNT_FIRE   = HW'(RPT_DLY);
  // A repeat rate no shorter than the initial delay simply restarts the full delay.
  localparam logic [HW-1:0] HCNT_RELOAD = (RPT_RATE >= RPT_DLY) ? '0 : HW'(RPT_DLY - RPT_RATE);

  logic [N_CH-1:0] s1_q, s2_q;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            tick_q, tick_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [SW-1:0]   scnt_q [N_CH];
  logic [SW-1:0]   scnt_d [N_CH];
  logic [HW-1:0]   hcnt_q [N_CH];
  logic [HW-1:0]   hcnt_d [N_CH];

  logic            sample_en;
  logic [N_CH-1:0] differ;
  logic [N_CH-1:0] accept;
  logic [N_CH-1:0] rpt_fire;

  // Sample instant: the last prescaler count; the registered tick marks it one clk later,
  // in the same cycle the updated level becomes visible.
  assign sample_en = (pcnt_q == PCNT_LAST);

  // Prescaler wraps at DIV-1 and raises tick for the following clk.
  always_comb begin
    pcnt_d = sample_en ? '0 : pcnt_q + 1'b1;
    tick_d = sample_en;
  end

  // Per-channel decisions: whether a new level is accepted or a repeat fires this sample.
  always_comb begin
    differ   = s2_q ^ level_q;
    accept   = '0;
    rpt_fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      accept[i]   = sample_en && differ[i] && (scnt_q[i] == SCNT_LAST);
      rpt_fire[i] = RPT_MASK[i] && sample_en && level_q[i] && !accept[i] &&
                    ((hcnt_q[i] + 1'b1) == HCNT_FIRE);
    end
  end

  // Stability counting, level update, strobes and hold-to-repeat counting.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    press_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      scnt_d[i] = scnt_q[i];
      hcnt_d[i] = hcnt_q[i];

      if (sample_en) begin
        if (differ[i]) begin
          if (accept[i]) begin
            level_d[i] = s2_q[i];
            scnt_d[i]  = '0;
            rise_d[i]  = s2_q[i];
            fall_d[i]  = ~s2_q[i];
          end else begin
            scnt_d[i] = scnt_q[i] + 1'b1;
          end
        end else begin
          scnt_d[i] = '0;
        end
      end

      if (!RPT_MASK[i] || accept[i] || !level_q[i]) begin
        hcnt_d[i] = '0;
      end else if (sample_en) begin
        if (rpt_fire[i]) begin
          hcnt_d[i] = HCNT_RELOAD;
        end else if (hcnt_q[i] < HCNT_FIRE) begin
          hcnt_d[i] = hcnt_q[i] + 1'b1;
        end
      end

      press_d[i] = rise_d[i] | rpt_fire[i];
    end
  end

  // All state, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      press_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        scnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
      for (int i = 0; i < N_CH; i++) begin
        scnt_q[i] <= scnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign press = press_q;
  assign tick  = tick_q;

endmodule
